// File: rtl/multi_freq_selector.sv
// Selects N_CH programmable FFT bins per frame from a LANES-wide bin stream and
// drains them serially, in channel order, on a backpressured output stream.
module multi_freq_selector #(
    parameter int unsigned SAMPLE_WIDTH = 64,
    parameter int unsigned LANES        = 4,
    parameter int unsigned K_WIDTH      = 14,
    parameter int unsigned N_CH         = 8,
    parameter int unsigned CH_WIDTH     = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [LANES*SAMPLE_WIDTH-1:0]   s_data,
    input  logic                            s_valid,
    input  logic                            s_first,
    input  logic                            cfg_we,
    input  logic [CH_WIDTH-1:0]             cfg_addr,
    input  logic [K_WIDTH-1:0]              cfg_k,
    input  logic                            cfg_commit,
    input  logic                            clr_flags,
    output logic [SAMPLE_WIDTH-1:0]         m_data,
    output logic [CH_WIDTH-1:0]             m_ch,
    output logic                            m_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            commit_pending,
    output logic                            overflow,
    output logic                            resync_err,
    output logic [31:0]                     frame_cnt
);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned LSEL_W = (LANE_W > 0) ? LANE_W : 1;
    localparam int unsigned BEAT_W = K_WIDTH - LANE_W;
    localparam logic [BEAT_W-1:0]   LAST_BEAT = '1;
    localparam logic [CH_WIDTH-1:0] LAST_CH   = CH_WIDTH'(N_CH - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state;
    logic [K_WIDTH-1:0]      shadow [N_CH];
    logic [K_WIDTH-1:0]      active [N_CH];
    logic [SAMPLE_WIDTH-1:0] cap    [N_CH];
    logic [SAMPLE_WIDTH-1:0] outb   [N_CH];
    logic [BEAT_W-1:0]       cnt;
    logic                    frame_done;

    logic [BEAT_W-1:0]       beat;
    logic                    resync;
    logic                    last_beat;
    logic                    commit_now;
    logic [CH_WIDTH-1:0]     next_ch;
    logic [SAMPLE_WIDTH-1:0] lanes    [LANES];
    logic [LSEL_W-1:0]       lane_sel [N_CH];
    logic [N_CH-1:0]         hit;

    always_comb begin
        beat       = s_first ? '0 : cnt;
        resync     = s_valid && s_first && (cnt != '0);
        last_beat  = s_valid && (beat == LAST_BEAT);
        // Table swap only between frames, so a frame never mixes tables.
        commit_now = commit_pending && (cnt == '0) && !s_valid;
        next_ch    = m_ch + 1'b1;
        for (int unsigned l = 0; l < LANES; l++) begin
            lanes[l] = s_data[l*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            hit[ch]      = s_valid && (active[ch][K_WIDTH-1 -: BEAT_W] == beat);
            lane_sel[ch] = LSEL_W'(active[ch] % K_WIDTH'(LANES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                shadow[ch] <= K_WIDTH'(ch);
                active[ch] <= K_WIDTH'(ch);
                cap[ch]    <= '0;
                outb[ch]   <= '0;
            end
            cnt            <= '0;
            frame_done     <= 1'b0;
            state          <= IDLE;
            m_valid        <= 1'b0;
            m_ch           <= '0;
            m_last         <= 1'b0;
            m_data         <= '0;
            commit_pending <= 1'b0;
            overflow       <= 1'b0;
            resync_err     <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            if (s_valid) begin
                cnt <= beat + 1'b1;
            end
            frame_done <= last_beat;

            // A resync discards the partial frame; hits on the new beat 0 still land.
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                if (hit[ch]) begin
                    cap[ch] <= lanes[lane_sel[ch]];
                end else if (resync) begin
                    cap[ch] <= '0;
                end
            end

            if (cfg_we && (32'(cfg_addr) < N_CH)) begin
                shadow[cfg_addr] <= cfg_k;
            end
            if (commit_now) begin
                for (int unsigned ch = 0; ch < N_CH; ch++) begin
                    active[ch] <= shadow[ch];
                end
                commit_pending <= 1'b0;
            end
            if (cfg_commit) begin
                commit_pending <= 1'b1;
            end

            if (clr_flags) begin
                overflow   <= 1'b0;
                resync_err <= 1'b0;
            end
            if (resync) begin
                resync_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_done) begin
                        for (int unsigned ch = 0; ch < N_CH; ch++) begin
                            outb[ch] <= cap[ch];
                        end
                        state     <= DRAIN;
                        m_valid   <= 1'b1;
                        m_ch      <= '0;
                        m_last    <= (N_CH == 1);
                        m_data    <= cap[0];
                        frame_cnt <= frame_cnt + 32'd1;
                    end
                end
                DRAIN: begin
                    if (frame_done) begin
                        overflow <= 1'b1;
                    end
                    if (m_ready) begin
                        if (m_last) begin
                            state   <= IDLE;
                            m_valid <= 1'b0;
                        end else begin
                            m_ch   <= next_ch;
                            m_last <= (next_ch == LAST_CH);
                            m_data <= outb[next_ch];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_freq_selector.sv
// Self-checking bench for multi_freq_selector: frames of bin n = f*256+n, expected
// outputs derived from the bin table as f*256 + k[ch].
module tb_multi_freq_selector;
    localparam int unsigned SW    = 64;
    localparam int unsigned LANES = 4;
    localparam int unsigned KW    = 6;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CHW   = 2;
    localparam int unsigned BEATS = (1 << KW) / LANES;

    typedef struct packed {
        logic [SW-1:0]  d;
        logic [CHW-1:0] ch;
        logic           last;
    } item_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [LANES*SW-1:0]   s_data = '0;
    logic                  s_valid = 1'b0;
    logic                  s_first = 1'b0;
    logic                  cfg_we = 1'b0;
    logic [CHW-1:0]        cfg_addr = '0;
    logic [KW-1:0]         cfg_k = '0;
    logic                  cfg_commit = 1'b0;
    logic                  clr_flags = 1'b0;
    logic [SW-1:0]         m_data;
    logic [CHW-1:0]        m_ch;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready = 1'b1;
    logic                  commit_pending;
    logic                  overflow;
    logic                  resync_err;
    logic [31:0]           frame_cnt;

    int          checks = 0;
    int          errors = 0;
    item_t       got_q[$];
    item_t       exp_q[$];
    int unsigned mdl_shadow [NCH];
    int unsigned mdl_active [NCH];
    bit          mdl_pending;
    int unsigned mdl_frames;
    bit          rec_en = 1'b0;
    bit          rand_ready = 1'b0;

    multi_freq_selector #(
        .SAMPLE_WIDTH(SW), .LANES(LANES), .K_WIDTH(KW), .N_CH(NCH), .CH_WIDTH(CHW)
    ) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_first(s_first),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_k(cfg_k), .cfg_commit(cfg_commit),
        .clr_flags(clr_flags), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .commit_pending(commit_pending),
        .overflow(overflow), .resync_err(resync_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Handshakes are recorded just before the edge that completes them.
    always @(negedge clk) begin
        if (rec_en && m_valid && m_ready) begin
            got_q.push_back(item_t'{d: m_data, ch: m_ch, last: m_last});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_beat(input int f, input int b, input bit first);
        s_valid = 1'b1;
        s_first = first;
        for (int l = 0; l < int'(LANES); l++) begin
            s_data[l*SW +: SW] = SW'(longint'(f) * 256 + longint'(b * int'(LANES) + l));
        end
        tick();
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic send_beats(input int f, input int from, input int to, input bit bubbles);
        for (int b = from; b <= to; b++) begin
            if (bubbles && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            send_beat(f, b, b == 0);
        end
    endtask

    task automatic push_expect(input int f);
        for (int ch = 0; ch < int'(NCH); ch++) begin
            exp_q.push_back(item_t'{d: SW'(longint'(f) * 256 + longint'(mdl_active[ch])),
                                    ch: CHW'(ch), last: (ch == int'(NCH) - 1)});
        end
        mdl_frames++;
    endtask

    // A frame is preceded by at least one idle cycle, which is where a pending
    // commit takes effect.
    task automatic run_frame(input int f, input bit bubbles, input bit accept);
        idle(1 + (bubbles ? int'($urandom_range(0, 2)) : 0));
        if (mdl_pending) begin
            mdl_active  = mdl_shadow;
            mdl_pending = 1'b0;
        end
        if (accept) push_expect(f);
        send_beats(f, 0, int'(BEATS) - 1, bubbles);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (got_q.size() < n && t < 400) begin
            tick();
            t++;
        end
    endtask

    task automatic cfg_write(input int a, input int unsigned k);
        cfg_we   = 1'b1;
        cfg_addr = CHW'(a);
        cfg_k    = KW'(k);
        tick();
        cfg_we = 1'b0;
        mdl_shadow[a] = k;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        mdl_pending = 1'b1;
    endtask

    task automatic do_reset();
        rec_en = 1'b0;
        reset  = 1'b1;
        idle(2);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int ch = 0; ch < int'(NCH); ch++) begin
            mdl_shadow[ch] = ch;
            mdl_active[ch] = ch;
        end
        mdl_pending = 1'b0;
        mdl_frames  = 0;
        rec_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m_valid, m_last, commit_pending, overflow, resync_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got v/l/cp/ov/rs=%b want 00000",
                     {m_valid, m_last, commit_pending, overflow, resync_err});
        end
        checks++;
        if (m_ch !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_out got ch=%0d data=%0d want 0 0", m_ch, m_data);
        end
        checks++;
        if (frame_cnt !== 32'(mdl_frames)) begin
            errors++;
            $display("FAIL reset_frame_cnt got %0d want %0d", frame_cnt, mdl_frames);
        end
    endtask

    task automatic test_default_frame();
        item_t g, e;
        m_ready = 1'b1;
        idle(1);
        push_expect(0);
        send_beats(0, 0, int'(BEATS) - 1, 1'b0);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got m_valid=%b want 0", m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_2cyc got m_valid=%b want 1", m_valid);
        end
        wait_out(int'(NCH));
        for (int i = 0; i < int'(NCH); i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL default[%0d] got no output want one item", i);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL default[%0d] got d=%0d ch=%0d last=%b want d=%0d ch=%0d last=%b",
                             i, g.d, g.ch, g.last, e.d, e.ch, e.last);
                end
            end
        end
        checks++;
        if (frame_cnt !== 32'(mdl_frames)) begin
            errors++;
            $display("FAIL default_frame_cnt got %0d want %0d", frame_cnt, mdl_frames);
        end
    endtask

    task automatic test_commit_between();
        item_t g, e;
        cfg_write(0, 63);
        cfg_write(1, 5);
        cfg_write(2, 5);
        cfg_write(3, 17);
        do_commit();
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL commit_set got %b want 1", commit_pending);
        end
        idle(1);
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL commit_applied got %b want 0", commit_pending);
        end
        run_frame(1, 1'b0, 1'b1);
        wait_out(int'(NCH));
        for (int i = 0; i < int'(NCH); i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_between[%0d] got no output want one item", i);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL commit_between[%0d] got d=%0d ch=%0d last=%b want d=%0d ch=%0d last=%b",
                             i, g.d, g.ch, g.last, e.d, e.ch, e.last);
                end
            end
        end
    endtask

    task automatic test_commit_midframe();
        item_t g, e;
        int unsigned x;
        idle(1);
        push_expect(2);
        send_beats(2, 0, 7, 1'b1);
        for (int a = 0; a < int'(NCH); a++) cfg_write(a, $urandom_range(0, 63));
        do_commit();
        send_beats(2, 8, int'(BEATS) - 1, 1'b1);
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL commit_midframe_hold got %b want 1", commit_pending);
        end
        // The copy cycle sees the shadow before this write.
        x = (mdl_shadow[0] + 32) % 64;
        mdl_active  = mdl_shadow;
        mdl_pending = 1'b0;
        cfg_write(0, x);
        checks++;
        if (commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL commit_midframe_apply got %b want 0", commit_pending);
        end
        run_frame(3, 1'b1, 1'b1);
        wait_out(2 * int'(NCH));
        for (int i = 0; i < 2 * int'(NCH); i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_midframe[%0d] got no output want one item", i);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL commit_midframe[%0d] got d=%0d ch=%0d last=%b want d=%0d ch=%0d last=%b",
                             i, g.d, g.ch, g.last, e.d, e.ch, e.last);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        item_t g, e, snap;
        m_ready = 1'b0;
        run_frame(4, 1'b1, 1'b1);
        idle(3);
        snap = item_t'{d: m_data, ch: m_ch, last: m_last};
        checks++;
        if (m_valid !== 1'b1 || snap !== exp_q[0]) begin
            errors++;
            $display("FAIL stall_head got v=%b d=%0d ch=%0d want v=1 d=%0d ch=%0d",
                     m_valid, snap.d, snap.ch, exp_q[0].d, exp_q[0].ch);
        end
        run_frame(5, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (m_valid !== 1'b1 || item_t'{d: m_data, ch: m_ch, last: m_last} !== snap) begin
            errors++;
            $display("FAIL stall_stable got v=%b d=%0d ch=%0d want v=1 d=%0d ch=%0d",
                     m_valid, m_data, m_ch, snap.d, snap.ch);
        end
        checks++;
        if (overflow !== 1'b1 || frame_cnt !== 32'(mdl_frames)) begin
            errors++;
            $display("FAIL overflow_set got ov=%b cnt=%0d want ov=1 cnt=%0d",
                     overflow, frame_cnt, mdl_frames);
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr got %b want 0", overflow);
        end
        m_ready = 1'b1;
        wait_out(int'(NCH));
        for (int i = 0; i < int'(NCH); i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL backpressure[%0d] got no output want one item", i);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL backpressure[%0d] got d=%0d ch=%0d last=%b want d=%0d ch=%0d last=%b",
                             i, g.d, g.ch, g.last, e.d, e.ch, e.last);
                end
            end
        end
        idle(20);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL dropped_frame got %0d extra items want 0", got_q.size());
        end
    endtask

    task automatic test_resync();
        item_t g, e;
        m_ready = 1'b1;
        idle(1);
        send_beats(6, 0, 6, 1'b1);
        push_expect(7);
        clr_flags = 1'b1;
        send_beat(7, 0, 1'b1);
        clr_flags = 1'b0;
        checks++;
        if (resync_err !== 1'b1) begin
            errors++;
            $display("FAIL resync_set_wins got %b want 1", resync_err);
        end
        send_beats(7, 1, int'(BEATS) - 1, 1'b1);
        wait_out(int'(NCH));
        idle(20);
        checks++;
        if (got_q.size() != int'(NCH)) begin
            errors++;
            $display("FAIL resync_count got %0d items want %0d", got_q.size(), NCH);
        end
        for (int i = 0; i < int'(NCH); i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL resync[%0d] got no output want one item", i);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL resync[%0d] got d=%0d ch=%0d last=%b want d=%0d ch=%0d last=%b",
                             i, g.d, g.ch, g.last, e.d, e.ch, e.last);
                end
            end
        end
        got_q.delete();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++;
        if (resync_err !== 1'b0) begin
            errors++;
            $display("FAIL resync_clr got %b want 0", resync_err);
        end
    endtask

    task automatic test_random();
        item_t g, e;
        int n;
        rand_ready = 1'b1;
        for (int f = 10; f < 16; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) cfg_write(int'($urandom_range(0, NCH - 1)), $urandom_range(0, 63));
                do_commit();
            end
            run_frame(f, 1'b1, 1'b1);
        end
        n = exp_q.size();
        wait_out(n);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL random[%0d] got no output want one item", i);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL random[%0d] got d=%0d ch=%0d last=%b want d=%0d ch=%0d last=%b",
                             i, g.d, g.ch, g.last, e.d, e.ch, e.last);
                end
            end
        end
        checks++;
        if (overflow !== 1'b0 || frame_cnt !== 32'(mdl_frames)) begin
            errors++;
            $display("FAIL random_status got ov=%b cnt=%0d want ov=0 cnt=%0d",
                     overflow, frame_cnt, mdl_frames);
        end
    endtask

    task automatic test_reset_mid_drain();
        item_t g, e;
        int t = 0;
        m_ready = 1'b1;
        idle(1);
        send_beats(8, 0, 2, 1'b0);
        send_beat(8, 0, 1'b1);
        send_beats(8, 1, int'(BEATS) - 1, 1'b0);
        checks++;
        if (resync_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_resync got %b want 1", resync_err);
        end
        while (got_q.size() < 2 && t < 100) begin
            tick();
            t++;
        end
        rec_en = 1'b0;
        reset  = 1'b1;
        tick();
        checks++;
        if ({m_valid, overflow, resync_err, commit_pending} !== 4'b0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_drain got v/ov/rs/cp=%b cnt=%0d want 0000 cnt=0",
                     {m_valid, overflow, resync_err, commit_pending}, frame_cnt);
        end
        do_reset();
        run_frame(9, 1'b0, 1'b1);
        wait_out(int'(NCH));
        idle(10);
        checks++;
        if (got_q.size() != int'(NCH)) begin
            errors++;
            $display("FAIL post_reset_count got %0d items want %0d", got_q.size(), NCH);
        end
        for (int i = 0; i < int'(NCH); i++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL post_reset[%0d] got no output want one item", i);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL post_reset[%0d] got d=%0d ch=%0d last=%b want d=%0d ch=%0d last=%b",
                             i, g.d, g.ch, g.last, e.d, e.ch, e.last);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_commit_between();
        test_commit_midframe();
        test_backpressure();
        test_resync();
        test_random();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
